// File: rtl/l2_pri_bank_arbiter.sv
// Two-master arbiter and zero-fill sequencer for one private L2 SRAM bank.
// Optional macro L2_ARB_FIXED_PRIO_EN: master 0 always wins on conflict.
module l2_pri_bank_arbiter #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       init_en_i,
  output logic                       init_done_o,
  input  logic [1:0]                 m_req_i,
  input  logic [1:0][31:0]           m_add_i,
  input  logic [1:0]                 m_wen_i,
  input  logic [1:0][BE_WIDTH-1:0]   m_be_i,
  input  logic [1:0][DATA_WIDTH-1:0] m_wdata_i,
  output logic [1:0]                 m_gnt_o,
  output logic [1:0]                 m_r_valid_o,
  output logic [1:0][DATA_WIDTH-1:0] m_r_rdata_o,
  output logic                       bank_req_o,
  output logic [ADDR_WIDTH-1:0]      bank_add_o,
  output logic                       bank_wen_o,
  output logic [BE_WIDTH-1:0]        bank_be_o,
  output logic [DATA_WIDTH-1:0]      bank_wdata_o,
  input  logic [DATA_WIDTH-1:0]      bank_rdata_i
);

  typedef enum logic [1:0] {BOOT, SCRUB, RUN} state_t;

  // One extra bit so the compare against the last word never wraps.
  localparam logic [ADDR_WIDTH:0] SCRUB_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] SCRUB_ONE  = (ADDR_WIDTH+1)'(1);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH:0]   scrub_cnt_reg, scrub_cnt_next;
  logic                  rr_reg, rr_next;
  logic                  resp_valid_reg, resp_id_reg;
  logic                  sel;
  logic [31:0]           offset;
  logic                  unused_bits;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= BOOT;
      scrub_cnt_reg  <= '0;
      rr_reg         <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_id_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      scrub_cnt_reg  <= scrub_cnt_next;
      rr_reg         <= rr_next;
      resp_valid_reg <= |m_gnt_o;
      resp_id_reg    <= m_gnt_o[1];
    end
  end

  always_comb begin
    state_next     = state_reg;
    scrub_cnt_next = scrub_cnt_reg;
    case (state_reg)
      BOOT:  state_next = init_en_i ? SCRUB : RUN;
      SCRUB: begin
        scrub_cnt_next = scrub_cnt_reg + SCRUB_ONE;
        if (scrub_cnt_reg == SCRUB_LAST) state_next = RUN;
      end
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    m_gnt_o = 2'b00;
    if (state_reg == RUN) begin
      case (m_req_i)
        2'b01:   m_gnt_o = 2'b01;
        2'b10:   m_gnt_o = 2'b10;
`ifdef L2_ARB_FIXED_PRIO_EN
        2'b11:   m_gnt_o = 2'b01;
`else
        2'b11:   m_gnt_o = rr_reg ? 2'b10 : 2'b01;
`endif
        default: m_gnt_o = 2'b00;
      endcase
    end
  end

`ifdef L2_ARB_FIXED_PRIO_EN
  assign rr_next = 1'b0;
`else
  // Point at the loser of the last grant; hold when idle.
  assign rr_next = m_gnt_o[0] ? 1'b1 : (m_gnt_o[1] ? 1'b0 : rr_reg);
`endif

  // Without a grant sel stays 0, so the bank sees master 0's signals.
  assign sel    = m_gnt_o[1];
  assign offset = m_add_i[sel] - BASE_ADDR;

  always_comb begin
    init_done_o  = (state_reg == RUN);
    bank_req_o   = 1'b0;
    bank_add_o   = offset[ADDR_WIDTH+1:2];
    bank_wen_o   = m_wen_i[sel];
    bank_be_o    = m_be_i[sel];
    bank_wdata_o = m_wdata_i[sel];
    case (state_reg)
      SCRUB: begin
        bank_req_o   = 1'b1;
        bank_add_o   = scrub_cnt_reg[ADDR_WIDTH-1:0];
        bank_wen_o   = 1'b0;
        bank_be_o    = '1;
        bank_wdata_o = '0;
      end
      RUN:     bank_req_o = |m_gnt_o;
      default: bank_req_o = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      assign m_r_valid_o[gi] = resp_valid_reg && (resp_id_reg == 1'(gi));
      assign m_r_rdata_o[gi] = bank_rdata_i;
    end
  endgenerate

  assign unused_bits = ^{offset[31:ADDR_WIDTH+2], offset[1:0], rr_reg};

endmodule

// File: tb/tb_l2_pri_bank_arbiter.sv
// Randomized scoreboard bench for l2_pri_bank_arbiter with a 16-word bank model.
// Honours L2_ARB_FIXED_PRIO_EN in its reference arbitration.
module tb_l2_pri_bank_arbiter;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int WORDS = 16;
  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               init_en = 1'b0;
  logic               init_done;
  logic [1:0]         m_req = '0;
  logic [1:0][31:0]   m_add = '0;
  logic [1:0]         m_wen = '0;
  logic [1:0][BW-1:0] m_be = '0;
  logic [1:0][DW-1:0] m_wdata = '0;
  logic [1:0]         m_gnt;
  logic [1:0]         m_r_valid;
  logic [1:0][DW-1:0] m_r_rdata;
  logic               bank_req;
  logic [AW-1:0]      bank_add;
  logic               bank_wen;
  logic [BW-1:0]      bank_be;
  logic [DW-1:0]      bank_wdata;
  logic [DW-1:0]      bank_rdata = '0;

  always #5 clk = ~clk;

  l2_pri_bank_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .init_en_i(init_en), .init_done_o(init_done),
    .m_req_i(m_req), .m_add_i(m_add), .m_wen_i(m_wen), .m_be_i(m_be),
    .m_wdata_i(m_wdata), .m_gnt_o(m_gnt), .m_r_valid_o(m_r_valid),
    .m_r_rdata_o(m_r_rdata), .bank_req_o(bank_req), .bank_add_o(bank_add),
    .bank_wen_o(bank_wen), .bank_be_o(bank_be), .bank_wdata_o(bank_wdata),
    .bank_rdata_i(bank_rdata)
  );

  // 1-cycle-latency SRAM macro
  logic [DW-1:0] sram [WORDS];
  logic preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < WORDS; i++) sram[i] <= 32'hA5A5_A5A5;
    end else if (bank_req) begin
      if (bank_wen) bank_rdata <= sram[bank_add];
      else for (int b = 0; b < BW; b++)
        if (bank_be[b]) sram[bank_add][8*b +: 8] <= bank_wdata[8*b +: 8];
    end
  end

  typedef struct { logic wen; logic [31:0] add; logic [3:0] be; logic [31:0] wdata; } tx_t;
  typedef struct { int id; logic rd; logic [31:0] data; } exp_t;

  tx_t         txq0[$], txq1[$];
  tx_t         cur[2];
  bit          cur_valid[2];
  exp_t        expq[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [WORDS];
  int          errors = 0, checks = 0;
  int          tb_cyc = 0;
  int          rr_model = 0;
  bit          strap = 1'b0;
  bit          rand_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 32'd4) % 32'(WORDS));
  endfunction

  function automatic tx_t mk_tx(input logic wen, input logic [31:0] add,
                                input logic [3:0] be, input logic [31:0] wdata);
    tx_t t;
    t.wen = wen; t.add = add; t.be = be; t.wdata = wdata;
    return t;
  endfunction

  function automatic tx_t rand_tx();
    logic [31:0] hi;
    hi = $urandom() & 32'hFFFF_FFC0;
    return mk_tx(1'($urandom_range(0, 1)),
                 BASE + hi + 32'($urandom_range(0, WORDS-1)) * 4 + 32'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), $urandom());
  endfunction

  // One clock cycle: drive at posedge+1, check against the model at posedge+2.
  task automatic step();
    bit run;
    logic [1:0] eg;
    int w, wd;
    exp_t e;
    for (int m = 0; m < 2; m++) begin
      if (!cur_valid[m]) begin
        if (m == 0 && txq0.size() > 0) begin cur[0] = txq0.pop_front(); cur_valid[0] = 1'b1; end
        else if (m == 1 && txq1.size() > 0) begin cur[1] = txq1.pop_front(); cur_valid[1] = 1'b1; end
        else if (rand_mode && $urandom_range(0, 2) == 0) begin cur[m] = rand_tx(); cur_valid[m] = 1'b1; end
      end
      m_req[m] = cur_valid[m]; m_wen[m] = cur[m].wen; m_add[m] = cur[m].add;
      m_be[m] = cur[m].be; m_wdata[m] = cur[m].wdata;
    end
    #1;
    run = tb_cyc >= (strap ? WORDS + 1 : 1);
    eg = 2'b00;
    w = -1;
    if (run) begin
      if (cur_valid[0] && cur_valid[1]) begin
`ifdef L2_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = rr_model;
`endif
      end else if (cur_valid[0]) w = 0;
      else if (cur_valid[1]) w = 1;
      if (w >= 0) eg[w] = 1'b1;
    end
    chk("init_done", 64'(init_done), 64'(run));
    chk("gnt", 64'(m_gnt), 64'(eg));
    if (!run) begin
      if (strap && tb_cyc >= 1) begin
        chk("scrub_req", 64'(bank_req), 64'd1);
        chk("scrub_addr", 64'(bank_add), 64'(tb_cyc - 1));
        chk("scrub_wr", 64'({bank_wen, bank_be, bank_wdata}), 64'({1'b0, 4'hF, 32'h0}));
        ref_mem[tb_cyc - 1] = 32'h0;
      end else begin
        chk("boot_req", 64'(bank_req), 64'd0);
      end
    end else begin
      chk("bank_req", 64'(bank_req), 64'(w >= 0));
      if (w >= 0) begin
        wd = word_of(cur[w].add);
        chk("bank_add", 64'(bank_add), 64'(wd));
        chk("bank_wen", 64'(bank_wen), 64'(cur[w].wen));
        e.id = w; e.rd = cur[w].wen; e.data = ref_mem[wd];
        expq.push_back(e);
        if (!cur[w].wen)
          for (int b = 0; b < BW; b++)
            if (cur[w].be[b]) ref_mem[wd][8*b +: 8] = cur[w].wdata[8*b +: 8];
        cur_valid[w] = 1'b0;
        rr_model = 1 - w;
      end
    end
    @(posedge clk); #1;
    tb_cyc++;
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called at posedge+1; two reset cycles, returns at posedge+1 with rst low.
  task automatic do_reset(input bit init);
    rst = 1'b1; init_en = init;
    @(posedge clk); #1;
    expq.delete();
    cur_valid[0] = 1'b0; cur_valid[1] = 1'b0;
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_bank_req", 64'(bank_req), 64'd0);
    chk("rst_gnt", 64'(m_gnt), 64'd0);
    chk("rst_rvalid", 64'(m_r_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; tb_cyc = 0; strap = init; rr_model = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++)
      if (cur_valid[0] || cur_valid[1] || txq0.size() > 0 || txq1.size() > 0) step();
    chk("drain_idle", 64'(cur_valid[0] || cur_valid[1]), 64'd0);
    step();
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents r_valid.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (m_r_valid[m]) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL stray_rvalid: master %0d got r_valid, required none", m);
        end else begin
          mon_e = expq.pop_front();
          chk("rvalid_id", 64'(m), 64'(mon_e.id));
          if (mon_e.rd) chk("rdata", 64'(m_r_rdata[m]), 64'(mon_e.data));
          $display("resp master=%0d %s data=%08h", m, mon_e.rd ? "rd" : "wr", m_r_rdata[m]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'hA5A5_A5A5;
    cur[0] = mk_tx(1'b1, BASE, 4'h0, 32'h0);
    cur[1] = cur[0];
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;

    // Init fill, then read-after-write conflict and a read of scrubbed word 7
    do_reset(1'b1);
    txq0.push_back(mk_tx(1'b0, BASE + 32'h40, 4'b0011, 32'hDEAD_BEEF));
    txq0.push_back(mk_tx(1'b1, BASE + 32'h1C, 4'hF, 32'h0));
    txq1.push_back(mk_tx(1'b1, BASE + 32'h40, 4'hF, 32'h0));
    run_steps(WORDS + 5);
    drain();

    // Reset in the middle of the scrub, masters kept requesting
    for (int i = 0; i < 2; i++) begin
      txq0.push_back(mk_tx(1'b1, BASE + 32'h8, 4'hF, 32'h0));
      txq1.push_back(mk_tx(1'b1, BASE + 32'hC, 4'hF, 32'h0));
    end
    do_reset(1'b1);
    run_steps(6);
    do_reset(1'b1);
    run_steps(WORDS + 3);
    drain();

    // No init, continuous contention
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      txq0.push_back(mk_tx(1'b1, BASE + 32'(i) * 4, 4'hF, 32'h0));
      txq1.push_back(mk_tx(1'b1, BASE + 32'(i + 8) * 4, 4'hF, 32'h0));
    end
    run_steps(14);
    drain();

    // Reset asserted in the grant cycle must swallow the response
    m_req = 2'b01; m_wen = 2'b11; m_add[0] = BASE;
    do_reset(1'b0);

    // Randomized traffic
    rand_mode = 1'b1;
    run_steps(400);
    rand_mode = 1'b0;
    drain();
    run_steps(2);
    chk("scoreboard_empty", 64'(expq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
